// File: rtl/scan_select_sequencer.sv
// ============================================================================
// Module   : scan_select_sequencer
// Purpose  : 2-bit select-code scanner feeding a 2-to-4 decoder (A/B).
//            Optional SCAN_ONEHOT_EN adds a registered onehot[3:0] output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_select_sequencer #(
  parameter int PRESCALE = 4,
  parameter int PRE_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       mode,
  output logic       A,
  output logic       B,
  output logic       valid,
  output logic       tick,
  output logic       done,
  output logic       busy,
  output logic [7:0] pass_cnt
`ifdef SCAN_ONEHOT_EN
  ,
  output logic [3:0] onehot
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PRESCALE - 1);

  state_t             r_state, w_state_n;
  logic [1:0]         r_code, w_code_n;
  logic [PRE_W-1:0]   r_pre, w_pre_n;
  logic               r_dir, w_dir_n;
  logic               r_mode, w_mode_n;
  logic               r_valid, w_valid_n;
  logic               r_tick, w_tick_n;
  logic               r_done, w_done_n;
  logic               r_busy, w_busy_n;
  logic [7:0]         r_pass, w_pass_n;
  logic               w_wrap;
  logic [1:0]         w_code_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_code  <= 2'b00;
      r_pre   <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_pass  <= 8'd0;
    end else begin
      r_state <= w_state_n;
      r_code  <= w_code_n;
      r_pre   <= w_pre_n;
      r_dir   <= w_dir_n;
      r_mode  <= w_mode_n;
      r_valid <= w_valid_n;
      r_tick  <= w_tick_n;
      r_done  <= w_done_n;
      r_busy  <= w_busy_n;
      r_pass  <= w_pass_n;
    end
  end

  // Wrap is the step out of the last code of a pass in the latched direction.
  assign w_wrap      = r_dir ? (r_code == 2'b00) : (r_code == 2'b11);
  assign w_code_step = r_dir ? (r_code - 2'd1) : (r_code + 2'd1);

  always_comb begin
    w_state_n = r_state;
    w_code_n  = 2'b00;
    w_pre_n   = '0;
    w_dir_n   = r_dir;
    w_mode_n  = r_mode;
    w_valid_n = 1'b0;
    w_tick_n  = 1'b0;
    w_done_n  = 1'b0;
    w_busy_n  = 1'b0;
    w_pass_n  = r_pass;

    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_n = ST_SCAN;
          w_dir_n   = dir;
          w_mode_n  = mode;
          w_code_n  = dir ? 2'b11 : 2'b00;
          w_pass_n  = 8'd0;
          w_valid_n = 1'b1;
          w_busy_n  = 1'b1;
        end
      end

      ST_SCAN: begin
        if (stop) begin
          w_state_n = ST_IDLE;
        end else if (r_pre == c_pre_last) begin
          if (w_wrap) begin
            w_pass_n = (r_pass == 8'hFF) ? r_pass : r_pass + 8'd1;
          end
          if (w_wrap && r_mode) begin
            w_state_n = ST_DONE;
            w_done_n  = 1'b1;
            w_busy_n  = 1'b1;
          end else begin
            w_code_n  = w_code_step;
            w_valid_n = 1'b1;
            w_busy_n  = 1'b1;
            w_tick_n  = 1'b1;
          end
        end else begin
          w_code_n  = r_code;
          w_pre_n   = r_pre + PRE_W'(1);
          w_valid_n = 1'b1;
          w_busy_n  = 1'b1;
        end
      end

      ST_DONE: begin
        w_state_n = ST_IDLE;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign A        = r_code[1];
  assign B        = r_code[0];
  assign valid    = r_valid;
  assign tick     = r_tick;
  assign done     = r_done;
  assign busy     = r_busy;
  assign pass_cnt = r_pass;

`ifdef SCAN_ONEHOT_EN
  logic [3:0] r_onehot, w_onehot_n;

  always_comb begin
    w_onehot_n = 4'b0000;
    if (w_valid_n) begin
      w_onehot_n[w_code_n] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_onehot <= 4'b0000;
    end else begin
      r_onehot <= w_onehot_n;
    end
  end

  assign onehot = r_onehot;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scan_select_sequencer.sv
// ============================================================================
// Module   : tb_scan_select_sequencer
// Purpose  : Randomized self-checking bench; two DUTs (PRESCALE=2, PRESCALE=1)
//            share stimulus and are compared to an elapsed-time model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scan_select_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, dir, mode;

  logic       a0, b0, v0, t0, d0, bz0;
  logic [7:0] p0;
  logic       a1, b1, v1, t1, d1, bz1;
  logic [7:0] p1;
`ifdef SCAN_ONEHOT_EN
  logic [3:0] oh0, oh1;
`endif

  scan_select_sequencer #(.PRESCALE(2), .PRE_W(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
    .A(a0), .B(b0), .valid(v0), .tick(t0), .done(d0), .busy(bz0), .pass_cnt(p0)
`ifdef SCAN_ONEHOT_EN
    , .onehot(oh0)
`endif
  );

  scan_select_sequencer #(.PRESCALE(1), .PRE_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
    .A(a1), .B(b1), .valid(v1), .tick(t1), .done(d1), .busy(bz1), .pass_cnt(p1)
`ifdef SCAN_ONEHOT_EN
    , .onehot(oh1)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a scan is described only by cycles elapsed since it began.
  int pre[2] = '{2, 1};
  int m_st[2];    // 0 idle, 1 scanning, 2 done cycle
  int m_t[2];
  int m_pass[2];
  bit m_dir[2];
  bit m_mode[2];

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_edge(input int i);
    if (rst) begin
      m_st[i] = 0;
      m_pass[i] = 0;
    end else begin
      case (m_st[i])
        0: if (start && !stop) begin
          m_st[i] = 1; m_t[i] = 0; m_pass[i] = 0;
          m_dir[i] = dir; m_mode[i] = mode;
        end
        1: if (stop) begin
          m_st[i] = 0;
        end else begin
          m_t[i]++;
          if (m_mode[i] && m_t[i] == 4 * pre[i]) begin
            m_st[i] = 2;
            m_pass[i] = 1;
          end else begin
            m_pass[i] = sat255(m_t[i] / (4 * pre[i]));
          end
        end
        default: m_st[i] = 0;
      endcase
    end
  endtask

  task automatic compare(input int i);
    logic [1:0] code_o, ec;
    logic       v_o, t_o, d_o, bz_o;
    logic [7:0] p_o;
    int         k;
    logic       ev, et, ed, eb;
    if (i == 0) begin
      code_o = {a0, b0}; v_o = v0; t_o = t0; d_o = d0; bz_o = bz0; p_o = p0;
    end else begin
      code_o = {a1, b1}; v_o = v1; t_o = t1; d_o = d1; bz_o = bz1; p_o = p1;
    end
    ec = 2'b00; ev = 1'b0; et = 1'b0; ed = 1'b0; eb = 1'b0;
    if (m_st[i] == 1) begin
      k  = (m_t[i] / pre[i]) % 4;
      ec = m_dir[i] ? 2'(3 - k) : 2'(k);
      ev = 1'b1; eb = 1'b1;
      et = (m_t[i] > 0) && (m_t[i] % pre[i] == 0);
    end else if (m_st[i] == 2) begin
      ed = 1'b1; eb = 1'b1;
    end
    check($sformatf("code%0d", i),  32'(code_o), 32'(ec));
    check($sformatf("valid%0d", i), 32'(v_o),    32'(ev));
    check($sformatf("tick%0d", i),  32'(t_o),    32'(et));
    check($sformatf("done%0d", i),  32'(d_o),    32'(ed));
    check($sformatf("busy%0d", i),  32'(bz_o),   32'(eb));
    check($sformatf("pass%0d", i),  32'(p_o),    32'(m_pass[i]));
`ifdef SCAN_ONEHOT_EN
    check($sformatf("onehot%0d", i), 32'((i == 0) ? oh0 : oh1),
          ev ? (32'd1 << ec) : 32'd0);
`endif
  endtask

  task automatic cyc(input bit r, input bit s, input bit sp, input bit d, input bit m);
    rst = r; start = s; stop = sp; dir = d; mode = m;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; dir = 1'b0; mode = 1'b0;
    for (int j = 0; j < 2; j++) begin m_st[j] = 0; m_t[j] = 0; m_pass[j] = 0; end

    // Reset with start held high, then continuous up with stray start and dir/mode noise.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int j = 0; j < 20; j++) cyc(0, (j == 6), 0, 1'($urandom), 1'($urandom));
    cyc(0, 0, 1, 0, 0);
    idle_cycles(3);

    // Single pass down, run to completion.
    cyc(0, 1, 0, 1, 1);
    idle_cycles(12);

    // Start and stop together in idle.
    cyc(0, 1, 1, 0, 0);
    idle_cycles(2);

    // Stop mid-scan while code is 10 on the PRESCALE=2 instance.
    cyc(0, 1, 0, 0, 1);
    idle_cycles(4);
    cyc(0, 0, 1, 0, 0);
    idle_cycles(2);

    // Reset mid-scan with start held.
    cyc(0, 1, 0, 1, 0);
    idle_cycles(5);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    idle_cycles(2);

    // Long continuous run drives the PRESCALE=1 pass counter into saturation.
    cyc(0, 1, 0, 0, 0);
    for (int j = 0; j < 1100; j++) cyc(0, 1'($urandom), 0, 1'($urandom), 1'($urandom));
    cyc(0, 0, 1, 0, 0);
    idle_cycles(2);

    // Random traffic.
    for (int j = 0; j < 3000; j++) begin
      cyc(($urandom % 300) == 0, ($urandom % 6) == 0, ($urandom % 30) == 0,
          1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scan_select_sequencer.md
# scan_select_sequencer

- Sequential select-code generator that sits directly upstream of the team's 2-to-4 decoder.
- Steps a 2-bit code (A = MSB, B = LSB) through 00..11, up or down, holding each code for a programmable number of clock cycles.
- Supports continuous or single-pass scanning with start/stop control, tick/done pulses and a pass counter.
- Its A/B outputs connect directly to the decoder's A/B inputs, e.g. to drive digit-enable or row-select lines.

## Interface
- PRESCALE, 4: clock cycles each code is held; legal range 1..2^PRE_W.
- PRE_W, 8: prescaler counter width.
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high; overrides all other inputs.
- start  input  1  begin scan; sampled in IDLE only.
- stop  input  1  abort scan; sampled in SCAN; in IDLE, blocks start.
- dir  input  1  direction: 0 = up (00→11), 1 = down (11→00); latched at start.
- mode  input  1  scan mode: 0 = continuous, 1 = single pass; latched at start.
- A  output  1  code MSB, to decoder A.
- B  output  1  code LSB, to decoder B.
- valid  output  1  code is live (state SCAN).
- tick  output  1  one-cycle pulse in the first cycle a new code is presented.
- done  output  1  one-cycle pulse when a single pass completes.
- busy  output  1  high in SCAN and DONE.
- pass_cnt  output  8  completed passes since the last start; saturates at 255.

## Operation
- States: IDLE, SCAN, DONE. All outputs are registered.
- Reset values: state = IDLE; {A,B} = 00; valid = 0; tick = 0; done = 0; busy = 0; pass_cnt = 0; prescaler = 0.
- IDLE:
  - start=1 and stop=0 → SCAN.
  - Latch dir and mode; load the code with 00 (up) or 11 (down); clear the prescaler; clear pass_cnt.
  - start=1 and stop=1 in the same cycle → remain in IDLE.
- SCAN:
  - The prescaler counts 0..PRESCALE-1.
  - At PRESCALE-1: prescaler → 0; the code steps ±1 mod 4; tick=1 on the following cycle.
- Wrap (11→00 up, 00→11 down):
  - pass_cnt increments, saturating at 255.
  - mode=0: scanning continues with the wrapped code.
  - mode=1: no wrap; go to DONE.
- stop=1 in SCAN → IDLE on the next edge, with no done pulse and no pass_cnt increment. stop has priority over a simultaneous wrap.
- DONE: lasts exactly one cycle; valid=0, done=1, busy=1, {A,B}=00; then → IDLE.
- start while in SCAN or DONE is ignored. Changes on dir or mode during a scan are ignored.
- PRESCALE=1: the code changes every cycle and tick stays high continuously while in SCAN.

## Timing
- Start latency: start sampled at edge k → from edge k+1: valid=1, busy=1, initial code presented. tick is 0 in that cycle; the initial code is not ticked.
- Code hold: each code is held exactly PRESCALE cycles. One pass takes 4×PRESCALE cycles from the first valid cycle.
- Code change and tick: the code changes on the edge where the prescaler = PRESCALE-1. tick is high for the cycle immediately following that edge.
- Single pass: the edge ending the last code's hold enters DONE. The next edge enters IDLE with busy=0.
- Stop latency: stop sampled at edge k → valid=0, busy=0, {A,B}=00 from edge k+1.
- Reset mid-scan: rst sampled at edge k → all outputs hold their reset values from edge k+1. start is ignored while rst=1.

## Configuration
- SCAN_ONEHOT_EN:
  - Defined: adds output onehot [3:0], registered in the same cycle as {A,B}.
  - Mapping: 00→0001, 01→0010, 10→0100, 11→1000, matching the decoder.
  - onehot = 0000 whenever valid=0; reset value 0000.
  - Used as a bench cross-check of the decoder.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Continuous up: PRESCALE=2, mode=0, dir=0, start pulse → {A,B} = 00,00,01,01,10,10,11,11,00,… ; tick on each first 01/10/11/00 cycle; pass_cnt=1 after 8 valid cycles and 2 after 16.
- Single pass down: PRESCALE=2, mode=1, dir=1 → 11,11,10,10,01,01,00,00; then one cycle with done=1, valid=0, {A,B}=00; then busy=0, pass_cnt=1.
- Stop mid-scan: stop asserted while code=10 → next cycle valid=0, busy=0, {A,B}=00, done never asserted, pass_cnt unchanged.
- Reset mid-scan, with start held high during rst → the cycle after rst is sampled, all outputs equal reset values; the scan starts only from the first start sampled after rst deasserts.
- Conflicts:
  - start and stop together in IDLE → stays IDLE, valid=0.
  - start pulsed during SCAN → sequence and pass_cnt unaffected.
  - PRESCALE=1 → code changes every cycle.
- SCAN_ONEHOT_EN defined → onehot tracks 0001,0010,0100,1000 in lockstep with {A,B}, and reads 0000 in IDLE and DONE.
